flag_tracker: RTL
=================

Name: flag_tracker

Overview:
- Parametrised flag collection manager for the Rally-X playfield; generalises the fixed 5-flag manager to N flags.
- Latches collision bursts from the color mapper and retires one collection per cycle, lowest index first. Owns flag visibility, per-level flag count and the running score, including the special-flag doubling bonus.
- Signals level clear to the game controller and supports re-arming flags for a new level without a global reset.

Parameters:
- NUM_FLAGS, 10, number of flags per level (2..32).
- CNT_W, $clog2(NUM_FLAGS+1), width of flagcount.
- SPECIAL_IDX, NUM_FLAGS-1, index of the special (doubling) flag.
- BASE_POINTS, 100, points for the 1st flag of a level.
- SCORE_W, 20, score width.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset; Reset==0 at posedge Clk clears all state
- flagBurst  in  NUM_FLAGS  per-flag collision from color mapper, level or pulse
- level_start  in  1  one-cycle pulse: re-arm all flags for a new level (score kept)
- flagDisplay  out  NUM_FLAGS  1 = flag still drawn
- flagcount  out  CNT_W  flags collected this level
- score  out  SCORE_W  accumulated score, saturating
- collect_valid  out  1  one-cycle pulse per retired collection
- collect_idx  out  5  index retired this cycle (valid with collect_valid)
- doubled  out  1  special flag taken this level
- level_clear  out  1  one-cycle pulse when the last flag is retired
- level_done  out  1  high from level_clear until level_start/reset

Behaviour:
- Reset values: flagDisplay all 1, flagcount 0, score 0, pending 0, doubled 0, collect_valid 0, collect_idx 0, level_clear 0, level_done 0, state RUN.
- Capture: at each posedge in RUN, pending <= (pending | (flagBurst & flagDisplay)) with the bit being retired this cycle removed. A burst on a flag that is hidden or already pending has no effect, so there is no double count.
- Retire: when any pending bit is set, the lowest index i is retired at the next posedge:
  - flagDisplay[i]<=0 and pending[i]<=0.
  - flagcount<=flagcount+1.
  - collect_valid<=1, collect_idx<=i.
- Latency: burst sampled at edge k; earliest display clear / score at edge k+1. Simultaneous bursts on m flags retire over m consecutive cycles, in ascending index order.
- Points for a retired flag: P = (flagcount+1)*BASE_POINTS, doubled (P<<1) if doubled is already 1.
  - If i==SPECIAL_IDX, the special flag itself scores undoubled, and doubled<=1 takes effect from the next award.
  - score <= min(score+P, 2^SCORE_W-1), computed at SCORE_W+2 bits before saturation.
- States:
  - RUN: capture and retire as above. The retire that makes flagcount==NUM_FLAGS pulses level_clear, sets level_done and moves to CLEARED.
  - CLEARED: flagBurst ignored, pending held 0, no awards.
- level_start (either state), at the posedge:
  - flagDisplay all 1; pending, flagcount and doubled cleared; level_done 0; state RUN.
  - score is unchanged.
  - A retire due in the same cycle is discarded and awards no score.
  - flagBurst present in the same cycle is dropped.
- Reset has priority over level_start. Mid-sequence reset abandons all pending bits.
- collect_valid and level_clear are never high for more than one consecutive cycle unless further retires follow. level_clear coincides with the final collect_valid.

Decomposition:
- Package rallyx_flag_pkg holds:
  - the state enum (RUN, CLEARED)
  - default NUM_FLAGS and BASE_POINTS constants
  - the SCORE_MAX function
- Sub-module flag_prio_enc (parametrised by NUM_FLAGS): lowest-set-bit index plus any-valid, purely combinational. It is instantiated once on pending.

Test Plan (NUM_FLAGS=10, BASE_POINTS=100, SPECIAL_IDX=9, SCORE_W=20):
- Reset==0 for 2 cycles -> flagDisplay=0x3FF, flagcount=0, score=0, level_done=0.
- flagBurst=0x001 held 5 cycles -> single collect_valid, idx 0, flagcount=1, score=100, flagDisplay=0x3FE; no further awards.
- One-cycle flagBurst=0x00E -> collect_valid on 3 consecutive cycles, idx 1,2,3; score +100,+200,+300; no loss of the pulse.
- Collect 9 first (1st flag) then 0 -> score 100 then +400 (200 doubled); doubled=1.
- Collect all 10 flags -> level_clear pulse with the 10th collect_valid, level_done=1; a later flagBurst=0x3FF yields no award.
- level_start asserted with pending=0x030 -> flagDisplay=0x3FF, flagcount=0, doubled=0, score unchanged, no collect_valid; preload score near 2^20-1 -> saturates at 0xFFFFF.

Source files
------------

// File: rtl/flag_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rallyx_flag_pkg
// Purpose  : Shared types and constants for the Rally-X flag tracker:
//            FSM state encoding, default flag/point constants and the
//            saturating score ceiling helper.
// Revision : 1.0  initial release
// ============================================================================
package rallyx_flag_pkg;

    // Level-progress state of the tracker.
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_CLEARED = 1'b1
    } flag_state_t;

    localparam int unsigned DEF_NUM_FLAGS   = 10;
    localparam int unsigned DEF_BASE_POINTS = 100;
    localparam int unsigned DEF_SCORE_W     = 20;

    // Largest value representable in a w-bit unsigned score.
    function automatic logic [63:0] score_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : flag_tracker_if
// Purpose  : Bundles the flag tracker's collision input, level control and
//            status outputs.
// Ports    : master - drives flagBurst/level_start, observes status
//            slave  - the tracker itself
// Revision : 1.0  initial release
// ============================================================================
interface flag_tracker_if
    import rallyx_flag_pkg::*;
#(
    parameter int NUM_FLAGS = DEF_NUM_FLAGS,
    parameter int CNT_W     = $clog2(NUM_FLAGS + 1),
    parameter int SCORE_W   = DEF_SCORE_W
);
    logic [NUM_FLAGS-1:0] flagBurst;
    logic                 level_start;
    logic [NUM_FLAGS-1:0] flagDisplay;
    logic [CNT_W-1:0]     flagcount;
    logic [SCORE_W-1:0]   score;
    logic                 collect_valid;
    logic [4:0]           collect_idx;
    logic                 doubled;
    logic                 level_clear;
    logic                 level_done;

    modport master (
        output flagBurst, level_start,
        input  flagDisplay, flagcount, score, collect_valid, collect_idx,
               doubled, level_clear, level_done
    );

    modport slave (
        input  flagBurst, level_start,
        output flagDisplay, flagcount, score, collect_valid, collect_idx,
               doubled, level_clear, level_done
    );
endinterface
`default_nettype wire

// File: rtl/flag_tracker_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : flag_prio_enc
// Purpose  : Combinational lowest-set-bit encoder.
// Ports    : vec   in  NUM_FLAGS  request vector
//            idx   out 5          index of lowest set bit (0 when none)
//            any   out 1          at least one bit set
// Revision : 1.0  initial release
// ============================================================================
module flag_prio_enc
    import rallyx_flag_pkg::*;
#(
    parameter int NUM_FLAGS = DEF_NUM_FLAGS
) (
    input  wire logic [NUM_FLAGS-1:0] vec,
    output logic      [4:0]           idx,
    output logic                      any
);
    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        idx = 5'd0;
        any = |vec;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
    end
endmodule
`default_nettype wire

// File: rtl/flag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : flag_tracker
// Purpose  : N-flag collection manager. Latches collision bursts into a
//            pending set, retires one flag per cycle (lowest index first),
//            maintains visibility, per-level count and a saturating score
//            with the special-flag doubling bonus, and reports level clear.
// Ports    : Clk    in  system clock
//            Reset  in  synchronous active-low reset
//            bus    slave modport of flag_tracker_if (burst, level_start,
//                   display, count, score, collect/level status)
// Revision : 1.0  initial release
// ============================================================================
module flag_tracker
    import rallyx_flag_pkg::*;
#(
    parameter int NUM_FLAGS   = DEF_NUM_FLAGS,
    parameter int CNT_W       = $clog2(NUM_FLAGS + 1),
    parameter int SPECIAL_IDX = NUM_FLAGS - 1,
    parameter int BASE_POINTS = DEF_BASE_POINTS,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  wire logic      Clk,
    input  wire logic      Reset,
    flag_tracker_if.slave  bus
);
    localparam int                   c_SUM_W      = SCORE_W + 2;
    localparam logic [63:0]          c_MAX64      = score_max(SCORE_W);
    localparam logic [c_SUM_W-1:0]   c_SCORE_MAX  = c_MAX64[c_SUM_W-1:0];
    localparam logic [CNT_W-1:0]     c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_LAST   = CNT_W'(NUM_FLAGS - 1);
    localparam logic [NUM_FLAGS-1:0] c_BIT0       = NUM_FLAGS'(1);
    localparam logic [c_SUM_W-1:0]   c_SUM_ONE    = c_SUM_W'(1);
    localparam logic [c_SUM_W-1:0]   c_BASE       = c_SUM_W'(BASE_POINTS);
    localparam logic [4:0]           c_SPECIAL    = 5'(SPECIAL_IDX);

    flag_state_t          r_state;
    logic [NUM_FLAGS-1:0] r_display;
    logic [NUM_FLAGS-1:0] r_pending;
    logic [CNT_W-1:0]     r_count;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_doubled;
    logic                 r_cv;
    logic [4:0]           r_idx;
    logic                 r_clear;
    logic                 r_done;

    logic [4:0]           w_idx;
    logic                 w_any;
    logic [NUM_FLAGS-1:0] w_ret_mask;
    logic [NUM_FLAGS-1:0] w_pending_nxt;
    logic [c_SUM_W-1:0]   w_mult;
    logic [c_SUM_W-1:0]   w_pts;
    logic [c_SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0]   w_score_nxt;

    flag_prio_enc #(.NUM_FLAGS(NUM_FLAGS)) u_prio (
        .vec (r_pending),
        .idx (w_idx),
        .any (w_any)
    );

    // The retire decision comes from the registered pending set, so a burst
    // sampled at one edge is awarded no earlier than the following edge.
    always_comb begin
        w_ret_mask    = w_any ? (c_BIT0 << w_idx) : '0;
        // Hidden flags are masked out so a burst on a retired flag cannot
        // re-enter pending; re-setting an already pending bit is harmless.
        w_pending_nxt = (r_pending | (bus.flagBurst & r_display)) & ~w_ret_mask;
        w_mult        = (c_SUM_W'(r_count) + c_SUM_ONE) * c_BASE;
        // The doubled flag reflects only specials already retired, so the
        // special flag itself scores at the plain rate.
        w_pts         = r_doubled ? {w_mult[c_SUM_W-2:0], 1'b0} : w_mult;
        w_sum         = c_SUM_W'(r_score) + w_pts;
        w_score_nxt   = (w_sum > c_SCORE_MAX) ? c_SCORE_MAX[SCORE_W-1:0]
                                              : w_sum[SCORE_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= ST_RUN;
            r_display <= '1;
            r_pending <= '0;
            r_count   <= '0;
            r_score   <= '0;
            r_doubled <= 1'b0;
            r_cv      <= 1'b0;
            r_idx     <= 5'd0;
            r_clear   <= 1'b0;
            r_done    <= 1'b0;
        end else if (bus.level_start) begin
            // Re-arm: any retire due this cycle and any same-cycle burst are
            // dropped; score carries over between levels.
            r_state   <= ST_RUN;
            r_display <= '1;
            r_pending <= '0;
            r_count   <= '0;
            r_doubled <= 1'b0;
            r_cv      <= 1'b0;
            r_clear   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cv    <= 1'b0;
            r_clear <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_pending <= w_pending_nxt;
                    if (w_any) begin
                        r_display <= r_display & ~w_ret_mask;
                        r_count   <= r_count + c_CNT_ONE;
                        r_score   <= w_score_nxt;
                        r_cv      <= 1'b1;
                        r_idx     <= w_idx;
                        if (w_idx == c_SPECIAL) r_doubled <= 1'b1;
                        if (r_count == c_CNT_LAST) begin
                            r_clear <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_CLEARED;
                        end
                    end
                end
                ST_CLEARED: begin
                    r_pending <= '0;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.flagDisplay   = r_display;
    assign bus.flagcount     = r_count;
    assign bus.score         = r_score;
    assign bus.collect_valid = r_cv;
    assign bus.collect_idx   = r_idx;
    assign bus.doubled       = r_doubled;
    assign bus.level_clear   = r_clear;
    assign bus.level_done    = r_done;

endmodule
`default_nettype wire
